// File: rtl/clk_edge_monitor.sv
// Samples a divided clock in the clk_i domain, emits rise/fall enable pulses and checks each
// half-period against HALF_PERIOD +/- TOL. Optional fault counter: CLK_EDGE_MONITOR_STATS_EN.
`timescale 1ns/1ps
module clk_edge_monitor #(
  parameter int HALF_PERIOD = 1,
  parameter int TOL         = 0,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = 16,
  parameter int CW          = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic          mon_clk_i,
  output logic          rise_o,
  output logic          fall_o,
  output logic          locked_o,
  output logic          fault_o,
  output logic [1:0]    state_o,
  output logic [CW-1:0] meas_o
`ifdef CLK_EDGE_MONITOR_STATS_EN
  ,
  output logic [7:0]    fault_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] HP_C    = CW'(HALF_PERIOD);
  localparam logic [CW-1:0] TOL_C   = CW'(TOL);
  localparam logic [CW-1:0] TO_C    = CW'(TIMEOUT);
  localparam logic [3:0]    LOCK_C  = 4'(LOCK_CNT);

  logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic          rise_q, rise_d, fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d, meas_q, meas_d;
  state_t        state_q, state_d;
  logic [3:0]    gcnt_q, gcnt_d;
  logic          armed_q, armed_d;
  logic          mon_edge, good, bad, timeout;
  logic [CW-1:0] diff;

  // Sync chain, edge pulses and half-period run counter
  always_comb begin
    sync1_d  = mon_clk_i;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    mon_edge = sync2_q ^ prev_q;
    rise_d   = sync2_q & ~prev_q;
    fall_d   = ~sync2_q & prev_q;
    meas_d   = meas_q;
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    if (mon_edge) begin
      meas_d = cnt_q;
      cnt_d  = {{(CW-1){1'b0}}, 1'b1};
    end
    diff    = (cnt_q >= HP_C) ? (cnt_q - HP_C) : (HP_C - cnt_q);
    good    = mon_edge && (diff <= TOL_C);
    bad     = mon_edge && !(diff <= TOL_C);
    timeout = !mon_edge && (cnt_q == TO_C);
  end

  // Lock FSM
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    armed_d = armed_q;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          armed_d = 1'b0;
          gcnt_d  = 4'd0;
        end
        ACQUIRE: begin
          if (timeout) begin
            armed_d = 1'b0;
            gcnt_d  = 4'd0;
          end else if (mon_edge && !armed_q) begin
            // The first edge after (re)arming has no trustworthy reference point
            armed_d = 1'b1;
          end else if (bad) begin
            armed_d = 1'b0;
            gcnt_d  = 4'd0;
          end else if (good) begin
            gcnt_d = gcnt_q + 4'd1;
            if (gcnt_q + 4'd1 == LOCK_C) state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (bad || timeout) state_d = FAULT;
        end
        FAULT: begin
          if (clr_i) begin
            state_d = ACQUIRE;
            armed_d = 1'b0;
            gcnt_d  = 4'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
      meas_q  <= '0;
      state_q <= IDLE;
      gcnt_q  <= 4'd0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
      meas_q  <= meas_d;
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      armed_q <= armed_d;
    end
  end

  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign locked_o = (state_q == LOCKED);
  assign fault_o  = (state_q == FAULT);
  assign state_o  = state_q;
  assign meas_o   = meas_q;

`ifdef CLK_EDGE_MONITOR_STATS_EN
  logic [7:0] fault_cnt_q, fault_cnt_d;

  always_comb begin
    fault_cnt_d = fault_cnt_q;
    if ((state_q != IDLE) && (bad || timeout) && (fault_cnt_q != 8'hFF))
      fault_cnt_d = fault_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) fault_cnt_q <= 8'd0;
    else       fault_cnt_q <= fault_cnt_d;
  end

  assign fault_cnt_o = fault_cnt_q;
`endif

endmodule
